// File: rtl/sev_seg_pkg.sv
// Shared types and constants for the seven-segment display blocks.
// Segment vectors are {g,f,e,d,c,b,a} with 1 meaning "lit" (logical level).
package sev_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b0000000;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_t;

  localparam seg_t SEG_HEX_0 = 7'h3F;
  localparam seg_t SEG_HEX_1 = 7'h06;
  localparam seg_t SEG_HEX_2 = 7'h5B;
  localparam seg_t SEG_HEX_3 = 7'h4F;
  localparam seg_t SEG_HEX_4 = 7'h66;
  localparam seg_t SEG_HEX_5 = 7'h6D;
  localparam seg_t SEG_HEX_6 = 7'h7D;
  localparam seg_t SEG_HEX_7 = 7'h07;
  localparam seg_t SEG_HEX_8 = 7'h7F;
  localparam seg_t SEG_HEX_9 = 7'h6F;
  localparam seg_t SEG_HEX_A = 7'h77;
  localparam seg_t SEG_HEX_B = 7'h7C;  // lowercase b
  localparam seg_t SEG_HEX_C = 7'h39;
  localparam seg_t SEG_HEX_D = 7'h5E;  // lowercase d
  localparam seg_t SEG_HEX_E = 7'h79;
  localparam seg_t SEG_HEX_F = 7'h71;

endpackage

// File: rtl/sev_seg.sv
// Combinational hex-nibble to seven-segment decoder, logical-lit output.
module sev_seg
  import sev_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sev_seg_scan_n.sv
// N-digit time-multiplexed seven-segment scanner with dead-time blanking,
// per-digit enable, leading-zero blanking and selectable output polarity.
module sev_seg_scan_n
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SLOT_CYCLES    = 24000,
  parameter int BLANK_CYCLES   = 240,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          lz_blank,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         sel,
  output logic [$clog2(NUM_DIGITS)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(SLOT_CYCLES);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_UNBLK = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt;
  scan_state_t           state, state_d;
  logic [3:0]            cur;
  logic                  vis;
  seg_t                  seg_q;
  logic [NUM_DIGITS-1:0] sel_q;

  logic [3:0] nib_d;
  logic       vis_d;
  logic       sample;
  seg_t       lit;

  always_comb begin
    state_d = state;
    case (state)
      BLANK:   if (cnt == CNT_UNBLK) state_d = SHOW;
      SHOW:    if (cnt == CNT_LAST)  state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  assign sample = (state == BLANK) && (cnt == CNT_UNBLK);

  // Walk from the top digit down so all_zero means "this digit and every digit above it are 0".
  always_comb begin
    logic all_zero;
    logic lz_hit;
    logic en_bit;
    all_zero = 1'b1;
    lz_hit   = 1'b0;
    en_bit   = 1'b0;
    nib_d    = 4'h0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (digits[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        nib_d  = digits[4*i +: 4];
        en_bit = digit_en[i];
        lz_hit = all_zero && (i != 0);
      end
    end
    vis_d = en_bit && !(lz_blank && lz_hit);
  end

  sev_seg u_dec (
    .nibble (cur),
    .seg    (lit)
  );

  // NOTE: every register here uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= '0;
      state <= BLANK;
      cur   <= 4'h0;
      vis   <= 1'b0;
      seg_q <= SEG_OFF;
      sel_q <= '0;
    end else begin
      cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      state <= state_d;
      if (cnt == CNT_LAST) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (sample) begin
        cur <= nib_d;
        vis <= vis_d;
      end
      // Outputs follow the current phase one cycle late; BLANK never drives a select.
      seg_q <= SEG_OFF;
      sel_q <= '0;
      if (state == SHOW && vis) begin
        seg_q <= lit;
        sel_q <= NUM_DIGITS'(1) << idx;
      end
    end
  end

  // Polarity is a pure inversion after the register, so reset is always the dark level.
  assign seg = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign sel = sel_q ^ {NUM_DIGITS{SEL_ACTIVE_LOW}};

endmodule
